// File: rtl/tinyrv1_mem_pkg.sv
// Shared data-memory request definitions for the tinyrv1 processor and its
// memory-side arbitration logic.
package tinyrv1_mem_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  // "type" is a reserved word, so the request kind lives in req_type.
  typedef struct packed {
    logic        val;
    logic        req_type;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmemreq_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating count of consecutive cycles the external requester was denied.
// Synchronous clear has priority over increment; the count holds at SAT.
module arb_wait_ctr #(
  parameter int CW  = 4,
  parameter int SAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] SAT_VAL = CW'(SAT);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT_VAL)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/proc_dmem_arb.sv
// Two-way arbiter for the single data-memory port: processor M stage has fixed
// priority, external requester is forced through after MAX_WAIT denied cycles.
module proc_dmem_arb
  import tinyrv1_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        proc_dmemreq_val,
  input  logic        proc_dmemreq_type,
  input  logic [31:0] proc_dmemreq_addr,
  input  logic [31:0] proc_dmemreq_wdata,
  output logic        proc_dmemreq_rdy,
  output logic        proc_dmemresp_val,
  output logic [31:0] proc_dmemresp_rdata,

  input  logic        ext_dmemreq_val,
  input  logic        ext_dmemreq_type,
  input  logic [31:0] ext_dmemreq_addr,
  input  logic [31:0] ext_dmemreq_wdata,
  output logic        ext_dmemreq_rdy,
  output logic        ext_dmemresp_val,
  output logic [31:0] ext_dmemresp_rdata,

  output logic        mem_dmemreq_val,
  output logic        mem_dmemreq_type,
  output logic [31:0] mem_dmemreq_addr,
  output logic [31:0] mem_dmemreq_wdata,
  input  logic [31:0] mem_dmemresp_rdata
);

  dmemreq_t        proc_req;
  dmemreq_t        ext_req;
  dmemreq_t        gnt_req;
  logic [CW-1:0]   wait_cnt;
  logic            force_ext;
  logic            grant_ext;
  logic            grant_proc;
  logic            resp_pend;
  logic            resp_own;

  assign proc_req = '{val: proc_dmemreq_val, req_type: proc_dmemreq_type,
                      addr: proc_dmemreq_addr, wdata: proc_dmemreq_wdata};
  assign ext_req  = '{val: ext_dmemreq_val, req_type: ext_dmemreq_type,
                      addr: ext_dmemreq_addr, wdata: ext_dmemreq_wdata};

  // Grants are suppressed while rst is high so nothing reaches memory during reset.
  assign force_ext  = (wait_cnt == CW'(MAX_WAIT));
  assign grant_ext  = !rst && ext_req.val && (!proc_req.val || force_ext);
  assign grant_proc = !rst && proc_req.val && !grant_ext;

  assign proc_dmemreq_rdy = grant_proc;
  assign ext_dmemreq_rdy  = grant_ext;

  arb_wait_ctr #(
    .CW  (CW),
    .SAT (MAX_WAIT)
  ) u_wait_ctr (
    .clk (clk),
    .rst (rst),
    .clr (!ext_req.val || grant_ext),
    .inc (ext_req.val && !grant_ext),
    .cnt (wait_cnt)
  );

  // NOTE: gnt_req gets a full default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_req = '0;
    if (grant_ext) begin
      gnt_req = ext_req;
    end else if (grant_proc) begin
      gnt_req = proc_req;
    end
  end

  assign mem_dmemreq_val   = gnt_req.val;
  assign mem_dmemreq_type  = gnt_req.req_type;
  assign mem_dmemreq_addr  = gnt_req.addr;
  assign mem_dmemreq_wdata = gnt_req.wdata;

  // One-deep response pipe: memory answers a read exactly one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pend <= 1'b0;
      resp_own  <= 1'b0;
    end else begin
      resp_pend <= gnt_req.val && (gnt_req.req_type == MEMREQ_READ);
      resp_own  <= grant_ext;
    end
  end

  assign proc_dmemresp_val   = !rst && resp_pend && !resp_own;
  assign ext_dmemresp_val    = !rst && resp_pend && resp_own;
  assign proc_dmemresp_rdata = proc_dmemresp_val ? mem_dmemresp_rdata : 32'h0;
  assign ext_dmemresp_rdata  = ext_dmemresp_val  ? mem_dmemresp_rdata : 32'h0;

endmodule

// File: tb/tb_proc_dmem_arb.sv
// Self-checking bench for proc_dmem_arb: a reference arbiter model plus a
// response scoreboard, with a behavioural one-cycle-latency memory behind the DUT.
module tb_proc_dmem_arb;

  localparam int MAX_WAIT = 4;
  localparam int CW       = 4;

  typedef struct packed {
    logic        pv;
    logic        ev;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        proc_dmemreq_val, proc_dmemreq_type;
  logic [31:0] proc_dmemreq_addr, proc_dmemreq_wdata;
  logic        proc_dmemreq_rdy, proc_dmemresp_val;
  logic [31:0] proc_dmemresp_rdata;
  logic        ext_dmemreq_val, ext_dmemreq_type;
  logic [31:0] ext_dmemreq_addr, ext_dmemreq_wdata;
  logic        ext_dmemreq_rdy, ext_dmemresp_val;
  logic [31:0] ext_dmemresp_rdata;
  logic        mem_dmemreq_val, mem_dmemreq_type;
  logic [31:0] mem_dmemreq_addr, mem_dmemreq_wdata;
  logic [31:0] mem_dmemresp_rdata;

  int          n_vec  = 0;
  int          n_miss = 0;
  exp_t        exp_q[$];
  int          m_cnt  = 0;
  logic [31:0] exp_mem [0:1023];
  logic [31:0] env_mem [0:1023];
  logic        obs_ext_rdy;
  logic        obs_proc_rdy;

  always #5 clk = ~clk;

  proc_dmem_arb #(.MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .proc_dmemreq_val    (proc_dmemreq_val),
    .proc_dmemreq_type   (proc_dmemreq_type),
    .proc_dmemreq_addr   (proc_dmemreq_addr),
    .proc_dmemreq_wdata  (proc_dmemreq_wdata),
    .proc_dmemreq_rdy    (proc_dmemreq_rdy),
    .proc_dmemresp_val   (proc_dmemresp_val),
    .proc_dmemresp_rdata (proc_dmemresp_rdata),
    .ext_dmemreq_val     (ext_dmemreq_val),
    .ext_dmemreq_type    (ext_dmemreq_type),
    .ext_dmemreq_addr    (ext_dmemreq_addr),
    .ext_dmemreq_wdata   (ext_dmemreq_wdata),
    .ext_dmemreq_rdy     (ext_dmemreq_rdy),
    .ext_dmemresp_val    (ext_dmemresp_val),
    .ext_dmemresp_rdata  (ext_dmemresp_rdata),
    .mem_dmemreq_val     (mem_dmemreq_val),
    .mem_dmemreq_type    (mem_dmemreq_type),
    .mem_dmemreq_addr    (mem_dmemreq_addr),
    .mem_dmemreq_wdata   (mem_dmemreq_wdata),
    .mem_dmemresp_rdata  (mem_dmemresp_rdata)
  );

  // Behavioural memory: word-indexed, read data one cycle after accept,
  // junk on the bus otherwise so ungated rdata outputs get noticed.
  always @(posedge clk) begin
    mem_dmemresp_rdata <= 32'hA5A5_5A5A;
    if (mem_dmemreq_val) begin
      if (mem_dmemreq_type) env_mem[mem_dmemreq_addr[11:2]] <= mem_dmemreq_wdata;
      else                  mem_dmemresp_rdata <= env_mem[mem_dmemreq_addr[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, compare against the model,
  // then advance the model and queue the response expected next cycle.
  task automatic step(input logic r,
                      input logic pv, input logic pt, input logic [31:0] pa, input logic [31:0] pd,
                      input logic ev, input logic et, input logic [31:0] ea, input logic [31:0] ed);
    logic        f, ge, gp;
    exp_t        e;
    logic        w_type;
    logic [31:0] w_addr, w_data;
    @(negedge clk);
    rst = r;
    proc_dmemreq_val = pv; proc_dmemreq_type = pt; proc_dmemreq_addr = pa; proc_dmemreq_wdata = pd;
    ext_dmemreq_val  = ev; ext_dmemreq_type  = et; ext_dmemreq_addr  = ea; ext_dmemreq_wdata  = ed;
    #1;
    f  = (m_cnt == MAX_WAIT);
    ge = !r && ev && (!pv || f);
    gp = !r && pv && !ge;
    w_type = ge ? et : (gp ? pt : 1'b0);
    w_addr = ge ? ea : (gp ? pa : 32'h0);
    w_data = ge ? ed : (gp ? pd : 32'h0);
    obs_ext_rdy  = ext_dmemreq_rdy;
    obs_proc_rdy = proc_dmemreq_rdy;

    check("rdy", {30'h0, proc_dmemreq_rdy, ext_dmemreq_rdy}, {30'h0, gp, ge});
    check("mem_val_type", {30'h0, mem_dmemreq_val, mem_dmemreq_type}, {30'h0, gp | ge, w_type});
    check("mem_addr", mem_dmemreq_addr, w_addr);
    check("mem_wdata", mem_dmemreq_wdata, w_data);

    if (exp_q.size() == 0) begin
      check("sb_empty", 32'h1, 32'h0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    if (r) e = '0;
    check("resp_val", {30'h0, proc_dmemresp_val, ext_dmemresp_val}, {30'h0, e.pv, e.ev});
    check("proc_rdata", proc_dmemresp_rdata, e.pv ? e.d : 32'h0);
    check("ext_rdata", ext_dmemresp_rdata, e.ev ? e.d : 32'h0);

    e = '0;
    if ((gp || ge) && !w_type) e = '{pv: gp, ev: ge, d: exp_mem[w_addr[11:2]]};
    if ((gp || ge) && w_type)  exp_mem[w_addr[11:2]] = w_data;
    exp_q.push_back(e);

    if (r || !ev || ge)        m_cnt = 0;
    else if (m_cnt < MAX_WAIT) m_cnt++;
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [9:0]  pat3;
  logic [11:0] pat4;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      exp_mem[i] = 32'hC0DE_0000 | 32'(i);
      env_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    exp_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    env_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    exp_q.push_back('0);

    // Reset with both requesters active: nothing may be granted.
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h108, 32'h1, 1'b1, 1'b1, 32'h10C, 32'h2);
    idle(1'b0);

    // 1: processor-only read.
    step(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1_rdy_same_cycle", {31'h0, obs_proc_rdy}, 32'h1);
    idle(1'b0);
    check("t1_rdata", proc_dmemresp_rdata, 32'hDEAD_BEEF);
    check("t1_ext_quiet", {31'h0, ext_dmemresp_val}, 32'h0);

    // 2: external write then read back.
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h1234_5678);
    idle(1'b0);
    check("t2_write_no_resp", {31'h0, ext_dmemresp_val}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    idle(1'b0);
    check("t2_rdata", ext_dmemresp_rdata, 32'h1234_5678);

    // 3: both held valid for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'h0);
      pat3[i] = obs_ext_rdy;
    end
    check("t3_ext_grant_pattern", {22'h0, pat3}, 32'h0000_0210);
    idle(1'b0);

    // 4: ext joins 3 cycles late, drops for one cycle at cycle 6, resumes.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h180, 32'(i), (i >= 3) && (i != 6), 1'b1, 32'h1C0, 32'(100 + i));
      pat4[i] = obs_ext_rdy;
    end
    check("t4_ext_grant_pattern", {20'h0, pat4}, 32'h0000_0800);
    idle(1'b0);

    // 5: seed words, then alternate processor and external reads.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b1, 32'h300 + 32'(4 * i), $urandom, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * (i % 4)), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      else            step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300 + 32'(4 * (i % 4)), 32'h0);
    end
    idle(1'b0);

    // 6: reset the cycle after a processor read is accepted.
    step(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0);
    check("t6_no_resp_in_rst", {31'h0, proc_dmemresp_val}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t6_resume_grant", {31'h0, obs_proc_rdy}, 32'h1);
    idle(1'b0);
    rd = proc_dmemresp_rdata;
    check("t6_resume_rdata", rd, 32'hDEAD_BEEF);

    // Random mix to finish.
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 32'(($urandom % 64) * 4), $urandom,
                 1'($urandom), 1'($urandom), 32'(($urandom % 64) * 4), $urandom);
    idle(1'b0);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
